// File: rtl/difficulty_select.sv
// difficulty_select: game difficulty selector driven by debounced up/down
// push-buttons, with a registered LED bar graph on red (game stopped) or
// green (game running) pins.
//
// Optional feature macro: DIFFICULTY_BLINK_EN
//   Defined     -> the red bar blinks from a free-running BLINK_BITS counter.
//   Not defined -> the red bar is steady and the blink counter is absent.

// Per-button front end: 2-flop synchroniser, stable-sample debouncer and
// rising-edge detector. rise_o is a single-cycle step request.
module difficulty_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted state; the
    // sample that would bring the count to DEBOUNCE_CYCLES is accepted.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debouncer state and the delayed copy used for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // Only a press (0 -> 1 of the accepted state) requests a step.
    assign rise_o = db_q & ~db_prev_q;

endmodule

module difficulty_select #(
    parameter int LEVELS          = 4,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_BITS      = 24,
    localparam int LVL_W          = $clog2(LEVELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gameover,
    input  logic                 btn_up,
    input  logic                 btn_down,
    output logic [LVL_W-1:0]     difficulty,
    output logic                 level_changed,
    output logic [LED_WIDTH-1:0] red_leds,
    output logic [LED_WIDTH-1:0] green_leds
);

    // Wide enough to hold (LEVELS * LED_WIDTH) without overflow.
    localparam int NW = LVL_W + $clog2(LED_WIDTH) + 1;
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LEVELS - 1);

    // Reject parameter sets the datapath cannot represent.
    if (LEVELS < 2) begin : g_bad_levels
        $error("difficulty_select: LEVELS must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("difficulty_select: DEBOUNCE_CYCLES must be at least 1");
    end
    if (BLINK_BITS < 1) begin : g_bad_blink
        $error("difficulty_select: BLINK_BITS must be at least 1");
    end

    logic                 up_req;
    logic                 dn_req;
    logic [LVL_W-1:0]     difficulty_q;
    logic [LVL_W-1:0]     difficulty_d;
    logic                 changed_q;
    logic                 changed_d;
    logic [NW-1:0]        lit_cnt;
    logic [LED_WIDTH-1:0] bar;
    logic [LED_WIDTH-1:0] red_q;
    logic [LED_WIDTH-1:0] red_d;
    logic [LED_WIDTH-1:0] green_q;
    logic [LED_WIDTH-1:0] green_d;
    logic                 blink_off;

    difficulty_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk_i  (clk),
        .rst_i  (rst),
        .raw_i  (btn_up),
        .rise_o (up_req)
    );

    difficulty_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_down (
        .clk_i  (clk),
        .rst_i  (rst),
        .raw_i  (btn_down),
        .rise_o (dn_req)
    );

    // Level update: only while stopped, conflicting requests cancel, and
    // both ends saturate without reporting a change.
    always_comb begin
        difficulty_d = difficulty_q;
        if (gameover && (up_req ^ dn_req)) begin
            if (up_req && (difficulty_q != MAX_LVL)) begin
                difficulty_d = difficulty_q + LVL_W'(1);
            end else if (dn_req && (difficulty_q != '0)) begin
                difficulty_d = difficulty_q - LVL_W'(1);
            end
        end
        changed_d = (difficulty_d != difficulty_q);
    end

    // Level register and its change strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            difficulty_q <= '0;
            changed_q    <= 1'b0;
        end else begin
            difficulty_q <= difficulty_d;
            changed_q    <= changed_d;
        end
    end

    // Bar graph: light the lowest floor((level+1)*LED_WIDTH/LEVELS) bits.
    always_comb begin
        lit_cnt = ((NW'(difficulty_q) + NW'(1)) * NW'(LED_WIDTH)) / NW'(LEVELS);
        bar     = '0;
        for (int i = 0; i < LED_WIDTH; i++) begin
            bar[i] = (NW'(i) < lit_cnt);
        end
    end

`ifdef DIFFICULTY_BLINK_EN
    logic [BLINK_BITS-1:0] blink_q;

    // Free-running blink timer; its MSB blanks the red bar half the time.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BLINK_BITS'(1);
        end
    end

    assign blink_off = blink_q[BLINK_BITS-1];
`else
    assign blink_off = 1'b0;
`endif

    // Route the bar to the pin set matching the game state.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        if (gameover) begin
            if (!blink_off) begin
                red_d = bar;
            end
        end else begin
            green_d = bar;
        end
    end

    // LED outputs are registered straight to the board pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            red_q   <= '0;
            green_q <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
        end
    end

    assign difficulty    = difficulty_q;
    assign level_changed = changed_q;
    assign red_leds      = red_q;
    assign green_leds    = green_q;

endmodule
